// File: rtl/fir_out_decimator_if.sv
// rtl/fir_out_decimator_if.sv - sample-in / sample-out handshake bundle for fir_out_decimator
interface fir_out_decimator_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fir_out_decimator.sv
// rtl/fir_out_decimator.sv - keep 1 of DECIM samples, round/saturate to 8 bits, buffer in FIFO
module fir_out_decimator #(
    parameter int DECIM = 4,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    fir_out_decimator_if.slave       bus,
    input  logic                     clr_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic                     ovf_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
    localparam logic signed [16:0] SAT_MAX = 17'sd127;
    localparam logic signed [16:0] SAT_MIN = -17'sd128;

    logic [PW-1:0] phase;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    mem [DEPTH];

    logic              keep;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              ovf_set;
    logic signed [16:0] ext;
    logic signed [16:0] rnd;
    logic signed [16:0] shifted;
    logic [7:0]        q;
    logic              clip;

    assign keep    = bus.in_valid && (phase == '0);
    assign full    = (count == CNT_FULL);
    assign pop     = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = keep && (!full || pop);
    assign ovf_set = keep && full && !pop;

    assign ext = {bus.in_data[15], bus.in_data};

    // Half-LSB offset before the shift gives round-half-up; no offset when SHIFT is 0.
    if (SHIFT > 0) begin : g_round
        localparam logic signed [16:0] HALF = 17'(1 << (SHIFT - 1));
        assign rnd = ext + HALF;
    end else begin : g_noround
        assign rnd = ext;
    end

    assign shifted = rnd >>> SHIFT;

    // Clamp the shifted value into the signed 8-bit range and flag clipping.
    always_comb begin
        q    = shifted[7:0];
        clip = 1'b0;
        if (shifted > SAT_MAX) begin
            q    = 8'h7F;
            clip = 1'b1;
        end else if (shifted < SAT_MIN) begin
            q    = 8'h80;
            clip = 1'b1;
        end
    end

    // Phase counter advances on every valid input and wraps at DECIM-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
        end else if (bus.in_valid) begin
            if (phase == PHASE_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PHASE_ONE;
            end
        end
    end

    // FIFO storage and pointers; pop on an empty FIFO is naturally blocked by out_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= q;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags; a set event in the same cycle as clr_flags takes priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            sat_flag <= (keep && clip) || (sat_flag && !clr_flags);
            ovf_flag <= ovf_set || (ovf_flag && !clr_flags);
        end
    end

    assign level         = count;
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = (count != '0) ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_fir_out_decimator.sv
// tb/tb_fir_out_decimator.sv - scoreboard bench for fir_out_decimator
module tb_fir_out_decimator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miss    = 0;

    logic rst_a, rst_b, rst_c;
    logic clr_a, clr_b, clr_c;
    logic [2:0] lvl_a, lvl_b, lvl_c;
    logic sat_a, sat_b, sat_c;
    logic ovf_a, ovf_b, ovf_c;

    fir_out_decimator_if a_if ();
    fir_out_decimator_if b_if ();
    fir_out_decimator_if c_if ();

    fir_out_decimator #(.DECIM(2), .SHIFT(4), .DEPTH(4)) dut_a (
        .clk(clk), .reset(rst_a), .bus(a_if.slave), .clr_flags(clr_a),
        .level(lvl_a), .sat_flag(sat_a), .ovf_flag(ovf_a)
    );
    fir_out_decimator #(.DECIM(1), .SHIFT(4), .DEPTH(4)) dut_b (
        .clk(clk), .reset(rst_b), .bus(b_if.slave), .clr_flags(clr_b),
        .level(lvl_b), .sat_flag(sat_b), .ovf_flag(ovf_b)
    );
    fir_out_decimator #(.DECIM(1), .SHIFT(0), .DEPTH(4)) dut_c (
        .clk(clk), .reset(rst_c), .bus(c_if.slave), .clr_flags(clr_c),
        .level(lvl_c), .sat_flag(sat_c), .ovf_flag(ovf_c)
    );

    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] qc [$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitors: every accepted output word is compared with the head of its queue.
    always @(negedge clk) begin
        if (a_if.out_valid && a_if.out_ready) begin
            if (qa.size() == 0) begin
                vectors++; miss++;
                $display("FAIL a_out: unexpected output %0d", a_if.out_data);
            end else chk("a_out", a_if.out_data, qa.pop_front());
        end
        if (b_if.out_valid && b_if.out_ready) begin
            if (qb.size() == 0) begin
                vectors++; miss++;
                $display("FAIL b_out: unexpected output %0d", b_if.out_data);
            end else chk("b_out", b_if.out_data, qb.pop_front());
        end
        if (c_if.out_valid && c_if.out_ready) begin
            if (qc.size() == 0) begin
                vectors++; miss++;
                $display("FAIL c_out: unexpected output %0d", c_if.out_data);
            end else chk("c_out", c_if.out_data, qc.pop_front());
        end
    end

    task automatic drain_c(input string name);
        int n;
        n = 0;
        while (c_if.out_valid && n < 50) begin
            step();
            n++;
        end
        sample();
        chk(name, c_if.out_valid, 0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        a_if.in_valid = 1'b1; a_if.in_data = 16'd100; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b1; b_if.in_data = 16'd100; b_if.out_ready = 1'b0;
        c_if.in_valid = 1'b1; c_if.in_data = 16'd100; c_if.out_ready = 1'b0;

        // reset held two cycles with valid input present
        step(); step();
        sample();
        chk("rst_valid", a_if.out_valid, 0);
        chk("rst_level", lvl_a, 0);
        chk("rst_data",  a_if.out_data, 0);
        chk("rst_sat",   sat_a, 0);
        chk("rst_ovf",   ovf_a, 0);
        chk("rst_level_c", lvl_c, 0);
        a_if.in_valid = 1'b0; b_if.in_valid = 1'b0; c_if.in_valid = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        step();

        // decimation by 2 with rounding
        a_if.out_ready = 1'b1;
        qa.push_back(8'd2);
        qa.push_back(8'hFF);
        a_if.in_valid = 1'b1;
        a_if.in_data = 16'd24;           step();
        a_if.in_data = 16'd1000;         step();
        a_if.in_data = 16'hFFE8;         step();
        a_if.in_data = 16'd5;            step();
        a_if.in_valid = 1'b0;
        step(); step();
        sample();
        chk("a_sat", sat_a, 0);
        chk("a_empty", a_if.out_valid, 0);

        // saturation and flag clearing
        b_if.out_ready = 1'b1;
        qb.push_back(8'h7F);
        qb.push_back(8'h80);
        b_if.in_valid = 1'b1;
        b_if.in_data = 16'd3000;         step();
        b_if.in_data = 16'hF060;         step();
        b_if.in_valid = 1'b0;
        step();
        sample();
        chk("b_sat_set", sat_b, 1);
        clr_b = 1'b1; step(); clr_b = 1'b0;
        sample();
        chk("b_sat_clr", sat_b, 0);
        // set wins over a simultaneous clear
        qb.push_back(8'h7F);
        b_if.in_valid = 1'b1; b_if.in_data = 16'd3000; clr_b = 1'b1;
        step();
        b_if.in_valid = 1'b0; clr_b = 1'b0;
        sample();
        chk("b_sat_setwins", sat_b, 1);

        // overflow on a full FIFO
        c_if.in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            c_if.in_data = 16'(i);
            if (i <= 4) qc.push_back(8'(i));
            step();
        end
        c_if.in_valid = 1'b0;
        sample();
        chk("c_full_level", lvl_c, 4);
        chk("c_ovf", ovf_c, 1);
        chk("c_full_head", c_if.out_data, 1);
        c_if.out_ready = 1'b1;
        drain_c("c_drain1");
        chk("c_drain1_level", lvl_c, 0);

        // full FIFO with simultaneous push and pop
        c_if.out_ready = 1'b0;
        clr_c = 1'b1; step(); clr_c = 1'b0;
        c_if.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            c_if.in_data = 16'(i);
            qc.push_back(8'(i));
            step();
        end
        c_if.in_data = 16'd9;
        qc.push_back(8'd9);
        c_if.out_ready = 1'b1;
        step();
        c_if.in_valid = 1'b0;
        c_if.out_ready = 1'b0;
        sample();
        chk("c_pp_level", lvl_c, 4);
        chk("c_pp_ovf", ovf_c, 0);
        c_if.out_ready = 1'b1;
        drain_c("c_drain2");

        // mid-operation reset: C with three entries, A sitting at phase 1
        c_if.out_ready = 1'b0;
        c_if.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_if.in_data = 16'(10 * (i + 1));
            step();
        end
        a_if.in_valid = 1'b1; a_if.in_data = 16'd32;
        qa.push_back(8'd2);
        c_if.in_valid = 1'b0;
        step();
        a_if.in_valid = 1'b0;
        sample();
        chk("c_pre_rst_level", lvl_c, 3);
        rst_c = 1'b0; rst_a = 1'b0;
        c_if.in_valid = 1'b1; c_if.in_data = 16'd40;
        a_if.in_valid = 1'b1; a_if.in_data = 16'd80;
        step();
        rst_c = 1'b1; rst_a = 1'b1;
        c_if.in_valid = 1'b0; a_if.in_valid = 1'b0;
        sample();
        chk("c_post_rst_level", lvl_c, 0);
        chk("c_post_rst_valid", c_if.out_valid, 0);
        c_if.in_valid = 1'b1; c_if.in_data = 16'd55; qc.push_back(8'd55);
        a_if.in_valid = 1'b1; a_if.in_data = 16'd48; qa.push_back(8'd3);
        step();
        c_if.in_valid = 1'b0; a_if.in_valid = 1'b0;
        sample();
        chk("c_first_kept", lvl_c, 1);
        c_if.out_ready = 1'b1;
        drain_c("c_drain3");

        for (int n = 0; n < 50 && (qa.size() + qb.size() + qc.size()) != 0; n++) step();
        chk("qa_left", qa.size(), 0);
        chk("qb_left", qb.size(), 0);
        chk("qc_left", qc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
